// File: rtl/countdown16_hex.sv
// Loadable 16-bit down-counter with pause, abort and a one-cycle done pulse.
// The registered count is also shown on four active-low seven-segment digits.
module countdown16_hex (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Enable,
    input  logic        Start,
    input  logic        Abort,
    input  logic [15:0] LoadVal,
    output logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic        expired,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0
);

    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            prev_start_q;
    logic            done_q, done_d;
    logic            req;

    assign req = Start & ~prev_start_q;

    // State, count, start history and done pulse registers
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            prev_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            prev_start_q <= Start;
            done_q       <= done_d;
        end
    end

    // Next-state and count update; Abort overrides everything below Clear
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (Abort) begin
            state_d = S_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (req) begin
                        count_d = LoadVal;
                        if (LoadVal != '0) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!Enable) begin
                        state_d = S_PAUSE;
                    end else if (count_q > CW'(1)) begin
                        count_d = count_q - CW'(1);
                    end else begin
                        count_d = '0;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (Enable) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign count   = count_q;
    assign done    = done_q;
    assign busy    = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign expired = (state_q == S_DONE);
    assign HEX3    = seg7(count_q[15:12]);
    assign HEX2    = seg7(count_q[11:8]);
    assign HEX1    = seg7(count_q[7:4]);
    assign HEX0    = seg7(count_q[3:0]);

endmodule

// File: tb/tb_countdown16_hex.sv
// Directed self-checking bench for countdown16_hex.
module tb_countdown16_hex;

    logic        Clock;
    logic        Clear;
    logic        Enable;
    logic        Start;
    logic        Abort;
    logic [15:0] LoadVal;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        expired;
    logic [6:0]  HEX3, HEX2, HEX1, HEX0;

    int checks = 0;
    int errors = 0;

    // {count, busy, done, expired}
    logic [18:0] obs;
    assign obs = {count, busy, done, expired};

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [27:0] HEX_ZERO = {4{7'b1000000}};

    countdown16_hex dut (
        .Clock(Clock), .Clear(Clear), .Enable(Enable), .Start(Start),
        .Abort(Abort), .LoadVal(LoadVal), .count(count), .busy(busy),
        .done(done), .expired(expired),
        .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_st(input string name, input logic [18:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got count=%h busy=%b done=%b expired=%b, want count=%h busy=%b done=%b expired=%b",
                     name, obs[18:3], obs[2], obs[1], obs[0], exp[18:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic test_reset();
        Clear = 1'b0; Enable = 1'b0; Start = 1'b0; Abort = 1'b0; LoadVal = '0;
        tick(); tick();
        Clear = 1'b1;
        expect_st("reset_state", {16'h0000, 1'b0, 1'b0, 1'b0});
        checks++;
        if ({HEX3, HEX2, HEX1, HEX0} !== HEX_ZERO) begin
            errors++;
            $display("FAIL reset_hex: got %b want %b", {HEX3, HEX2, HEX1, HEX0}, HEX_ZERO);
        end
    endtask

    task automatic test_countdown();
        LoadVal = 16'h0003; Enable = 1'b1; Start = 1'b1;
        tick(); Start = 1'b0;
        expect_st("cd_load3", {16'h0003, 1'b1, 1'b0, 1'b0});
        tick(); expect_st("cd_2", {16'h0002, 1'b1, 1'b0, 1'b0});
        tick(); expect_st("cd_1", {16'h0001, 1'b1, 1'b0, 1'b0});
        tick(); expect_st("cd_0_done", {16'h0000, 1'b0, 1'b1, 1'b1});
        tick(); expect_st("cd_expired", {16'h0000, 1'b0, 1'b0, 1'b1});
        tick(); expect_st("cd_nowrap", {16'h0000, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic test_pause();
        LoadVal = 16'h0010; Enable = 1'b1; Start = 1'b1;
        tick(); Start = 1'b0;
        expect_st("pz_load", {16'h0010, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) tick();
        expect_st("pz_after4", {16'h000C, 1'b1, 1'b0, 1'b0});
        Enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        expect_st("pz_hold", {16'h000C, 1'b1, 1'b0, 1'b0});
        Enable = 1'b1;
        tick(); expect_st("pz_resume_edge", {16'h000C, 1'b1, 1'b0, 1'b0});
        tick(); expect_st("pz_first_dec", {16'h000B, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic test_zero_load();
        Abort = 1'b1;
        tick(); Abort = 1'b0;
        expect_st("zl_abort", {16'h0000, 1'b0, 1'b0, 1'b0});
        LoadVal = 16'h0000; Start = 1'b1;
        tick(); Start = 1'b0;
        expect_st("zl_done", {16'h0000, 1'b0, 1'b1, 1'b1});
        checks++;
        if ({HEX3, HEX2, HEX1, HEX0} !== HEX_ZERO) begin
            errors++;
            $display("FAIL zl_hex: got %b want %b", {HEX3, HEX2, HEX1, HEX0}, HEX_ZERO);
        end
        tick(); expect_st("zl_one_pulse", {16'h0000, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic test_abort();
        LoadVal = 16'h00A7; Enable = 1'b1; Start = 1'b1;
        tick(); Start = 1'b0;
        tick();
        expect_st("ab_a6", {16'h00A6, 1'b1, 1'b0, 1'b0});
        LoadVal = 16'h1234; Start = 1'b1;
        tick(); Start = 1'b0;
        expect_st("ab_restart_ignored", {16'h00A5, 1'b1, 1'b0, 1'b0});
        Abort = 1'b1; Start = 1'b1;
        tick(); Abort = 1'b0; Start = 1'b0;
        expect_st("ab_idle", {16'h0000, 1'b0, 1'b0, 1'b0});
        tick(); expect_st("ab_no_done", {16'h0000, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_hex();
        logic [15:0] vals [5] = '{16'hBEEF, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        logic [15:0] v;
        logic [27:0] exp;
        Enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v = vals[i];
            Abort = 1'b1; tick(); Abort = 1'b0;
            LoadVal = v; Start = 1'b1;
            tick(); Start = 1'b0;
            tick();
            exp = {SEG[v[15:12]], SEG[v[11:8]], SEG[v[7:4]], SEG[v[3:0]]};
            checks++;
            if ({HEX3, HEX2, HEX1, HEX0} !== exp || count !== v) begin
                errors++;
                $display("FAIL hex_%h: got count=%h hex=%b want count=%h hex=%b",
                         v, count, {HEX3, HEX2, HEX1, HEX0}, v, exp);
            end
        end
    endtask

    task automatic test_clear_mid_run();
        Abort = 1'b1; tick(); Abort = 1'b0;
        LoadVal = 16'h0050; Enable = 1'b1; Start = 1'b1;
        tick(); Start = 1'b0;
        tick();
        expect_st("cl_running", {16'h004F, 1'b1, 1'b0, 1'b0});
        Clear = 1'b0;
        tick();
        expect_st("cl_reset", {16'h0000, 1'b0, 1'b0, 1'b0});
        checks++;
        if ({HEX3, HEX2, HEX1, HEX0} !== HEX_ZERO) begin
            errors++;
            $display("FAIL cl_hex: got %b want %b", {HEX3, HEX2, HEX1, HEX0}, HEX_ZERO);
        end
        Clear = 1'b1;
    endtask

    task automatic test_start_through_clear();
        Clear = 1'b0; Start = 1'b1; Abort = 1'b1; LoadVal = 16'h0005;
        tick();
        expect_st("stc_clear_wins", {16'h0000, 1'b0, 1'b0, 1'b0});
        Clear = 1'b1; Abort = 1'b0;
        tick();
        expect_st("stc_request", {16'h0005, 1'b1, 1'b0, 1'b0});
        tick();
        expect_st("stc_held_no_reload", {16'h0004, 1'b1, 1'b0, 1'b0});
        Start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_zero_load();
        test_abort();
        test_hex();
        test_clear_mid_run();
        test_start_through_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown16_hex.md
COUNTDOWN16_HEX -- requirements
Module: countdown16_hex

Interface
REQ-001 Clock  input  1  — sole clock; all state updates on its rising edge.
REQ-002 Clear  input  1  — synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-003 Enable  input  1  — count permission; when 0 in RUN, the count holds (pause).
REQ-004 Start  input  1  — level input, rising-edge detected internally; each 0->1 transition is one start request.
REQ-005 Abort  input  1  — when 1, returns the block to IDLE with count cleared.
REQ-006 LoadVal  input  16  — start value, captured on the cycle the start request is accepted.
REQ-007 count  output  16  — current remaining value, registered.
REQ-008 busy  output  1  — 1 in RUN or PAUSE.
REQ-009 done  output  1  — one-cycle pulse on arrival at zero.
REQ-010 expired  output  1  — level, 1 while in DONE.
REQ-011 HEX3, HEX2, HEX1, HEX0  output  7 each  — active-low seven-segment digits of count[15:12], [11:8], [7:4], [3:0]; bit0=a … bit6=g.

Function
REQ-012 States: IDLE, RUN, PAUSE, DONE, encoded in 2 bits.
REQ-013 Start edge detection: the registered previous Start value resets to 0; request = Start & ~prev.
REQ-014 IDLE + request: count <= LoadVal. Next state is RUN if LoadVal != 0, otherwise DONE.
REQ-015 RUN, Enable=1, count > 1: count decrements by 1 per cycle.
REQ-016 RUN, Enable=1, count == 1: count <= 0, state <= DONE, done=1 in the cycle after that edge.
REQ-017 RUN, Enable=0: state <= PAUSE and count holds.
REQ-018 PAUSE, Enable=1: state <= RUN. No decrement occurs on the resume edge.
REQ-019 Entry to DONE from a zero LoadVal also produces exactly one done pulse.
REQ-020 done is 1 for exactly one cycle per DONE entry and is 0 in every other cycle.
REQ-021 DONE: count holds at 0 and expired=1.
REQ-022 DONE + request: behaves exactly as IDLE + request (restart).
REQ-023 Start requests in RUN or PAUSE are ignored; there is no mid-run reload.
REQ-024 Abort=1 in any state: next state IDLE, count <= 0, no done pulse. Abort has priority over request and Enable.
REQ-025 The count never wraps: no decrement occurs from 0 in any state.
REQ-026 Counting is unsigned binary.
REQ-027 HEX outputs are combinational from registered count and have the same cycle timing as count.
REQ-028 HEX encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
REQ-029 busy and expired are decoded from the registered state, with no extra latency.

Reset
REQ-030 Clear=0 at a rising edge: state IDLE, count=0, prev Start=0, done=0, busy=0, expired=0, all HEX = 1000000.
REQ-031 Clear has priority over Abort, Start and Enable.
REQ-032 Clear asserted mid-RUN discards the count immediately at that edge.
REQ-033 Start held high through the release of Clear counts as a request on the first cycle after release, because prev Start was reset to 0.

Verification
REQ-034 Clear=0 for 2 cycles, then 1 -> count=0000, HEX0..3 = 1000000, busy=0, expired=0.
REQ-035 LoadVal=0x0003, Enable=1, Start pulse -> count 3,2,1,0 on consecutive cycles; done=1 for exactly one cycle; expired=1 thereafter; busy=0.
REQ-036 LoadVal=0x0010, Start, then Enable=0 after 4 decrements for 5 cycles -> count holds at 0x000C in PAUSE; on Enable=1 the first decrement occurs 2 edges later.
REQ-037 LoadVal=0x0000, Start -> DONE next cycle, one done pulse, count=0, HEX=1000000.
REQ-038 Mid-RUN at count 0x00A5: Abort=1 -> IDLE, count=0, no done pulse. A second Start during RUN leaves count unaffected.
REQ-039 LoadVal=0xBEEF captured, Enable=0 -> HEX3=0000011, HEX2=0000110, HEX1=0000110, HEX0=0001110. Clear=0 mid-RUN -> all outputs at reset values at the next edge.
